// File: rtl/au_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : au_pkg
//  Description : Shared types for the arithmetic-unit arbiter: opcode and
//                FSM state encodings plus the requester count.
//  Revision    : 1.0 - initial release
// ============================================================================
package au_pkg;

    // Number of requesters sharing the datapath
    localparam int unsigned AU_NUM_REQ = 2;

    // Opcode carried on req_op
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ASHR = 2'b10,
        OP_ILL  = 2'b11
    } au_op_e;

    // Arbiter control state
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } au_state_e;

endpackage : au_pkg
`default_nettype wire

// File: rtl/au_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : au_rr_grant
//  Description : Two-way round-robin picker. When both requesters are valid
//                the one that was NOT served last wins; otherwise the single
//                valid requester wins. Output is one-hot or zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module au_rr_grant
    import au_pkg::*;
(
    input  logic [AU_NUM_REQ-1:0] valid_i,
    input  logic                  last_i,
    output logic [AU_NUM_REQ-1:0] grant_o
);

    // Requester 0 wins alone, or on a tie when requester 1 was served last
    assign grant_o[0] = valid_i[0] & (~valid_i[1] | last_i);
    // Requester 1 wins alone, or on a tie when requester 0 was served last
    assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);

endmodule : au_rr_grant
`default_nettype wire

// File: rtl/au_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : au_arbiter
//  Description : Shares one N-bit add/sub/arithmetic-shift datapath between
//                two requesters. Round-robin grant in IDLE, one EXEC cycle
//                computing from registered operands, then RESP holding a
//                registered result until the granted requester accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module au_arbiter
    import au_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [AU_NUM_REQ-1:0]              req_valid,
    output logic [AU_NUM_REQ-1:0]              req_ready,
    input  logic [AU_NUM_REQ-1:0][N-1:0]       req_a,
    input  logic [AU_NUM_REQ-1:0][N-1:0]       req_b,
    input  logic [AU_NUM_REQ-1:0][1:0]         req_op,
    output logic [AU_NUM_REQ-1:0]              rsp_valid,
    input  logic [AU_NUM_REQ-1:0]              rsp_ready,
    output logic [N-1:0]                       rsp_result,
    output logic                               rsp_cout,
    output logic                               rsp_err
);

    au_state_e                 state_q;
    logic                      rr_ptr_q;     // requester served most recently
    logic                      gnt_q;        // requester owning the transaction
    logic [N-1:0]              a_q;
    logic [N-1:0]              b_q;
    au_op_e                    op_q;
    logic [N-1:0]              res_q;
    logic                      cout_q;
    logic                      err_q;
    logic [AU_NUM_REQ-1:0]     rsp_valid_q;

    logic [AU_NUM_REQ-1:0]     w_grant;
    logic                      w_gnt_idx;
    logic [N:0]                w_sum;
    logic [N-1:0]              w_diff;
    logic [N-1:0]              w_shr;

    au_rr_grant u_rr_grant (
        .valid_i (req_valid),
        .last_i  (rr_ptr_q),
        .grant_o (w_grant)
    );

    // Grant index; only meaningful while w_grant is non-zero
    assign w_gnt_idx = w_grant[1];

    // Accept only in IDLE; held low while reset is asserted so every output
    // reads zero during reset regardless of incoming requests
    assign req_ready = (rst_n && (state_q == S_IDLE)) ? w_grant : '0;

    // Datapath candidates from the registered operands; EXEC selects one
    assign w_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign w_diff = a_q - b_q;
    assign w_shr  = $signed(a_q) >>> b_q[1:0];

    // Control FSM with operand, result and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b1;
            gnt_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            res_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_valid) begin
                        gnt_q   <= w_gnt_idx;
                        a_q     <= req_a[w_gnt_idx];
                        b_q     <= req_b[w_gnt_idx];
                        op_q    <= au_op_e'(req_op[w_gnt_idx]);
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            res_q  <= w_sum[N-1:0];
                            cout_q <= w_sum[N];
                            err_q  <= 1'b0;
                        end
                        OP_SUB: begin
                            res_q  <= w_diff;
                            cout_q <= 1'b0;
                            err_q  <= 1'b0;
                        end
                        OP_ASHR: begin
                            res_q  <= w_shr;
                            cout_q <= 1'b0;
                            err_q  <= 1'b0;
                        end
                        default: begin
                            res_q  <= '0;
                            cout_q <= 1'b0;
                            err_q  <= 1'b1;
                        end
                    endcase
                    rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    // Only the owner's rsp_ready completes the transaction
                    if (rsp_ready[gnt_q]) begin
                        rr_ptr_q    <= gnt_q;
                        rsp_valid_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = res_q;
    assign rsp_cout   = cout_q;
    assign rsp_err    = err_q;

endmodule : au_arbiter
`default_nettype wire

// File: tb/tb_au_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_au_arbiter
//  Description : Self-checking bench for au_arbiter (N=4): directed vector
//                table, hand-written multi-cycle sequences and randomized
//                single-requester traffic against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_au_arbiter;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][N-1:0]    req_a;
    logic [1:0][N-1:0]    req_b;
    logic [1:0][1:0]      req_op;
    logic [1:0]           rsp_valid;
    logic [1:0]           rsp_ready;
    logic [N-1:0]         rsp_result;
    logic                 rsp_cout;
    logic                 rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    au_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] res;
        logic       cout;
        logic       err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {err, cout, res} computed with integer arithmetic
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        int s;
        int v;
        logic [3:0] r;
        logic c;
        logic e;
        r = 4'h0; c = 1'b0; e = 1'b0;
        case (op)
            2'd0: begin
                s = int'(a) + int'(b);
                r = 4'(s % 16);
                c = (s >= 16);
            end
            2'd1: begin
                s = int'(a) - int'(b) + 16;
                r = 4'(s % 16);
            end
            2'd2: begin
                v = (a >= 4'd8) ? int'(a) - 16 : int'(a);
                for (int k = 0; k < int'(b) % 4; k++)
                    v = (v < 0) ? -((1 - v) / 2) : v / 2;   // floor halving
                r = 4'((v + 16) % 16);
            end
            default: e = 1'b1;
        endcase
        return {e, c, r};
    endfunction

    // One complete transaction from an idle DUT, with optional response stall
    task automatic do_op(input int r, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [5:0] exp,
                         input int stall, input bit poke, input string tag);
        int waited;
        req_a[r] = a; req_b[r] = b; req_op[r] = op; req_valid[r] = 1'b1;
        #1;
        waited = 0;
        while (req_ready[r] !== 1'b1 && waited < 10) begin
            tick(); #1; waited++;
        end
        chk({tag, ".grant"}, req_ready, 32'(2'b01 << r));
        chk({tag, ".grant_wait"}, waited, 0);
        tick();
        req_valid[r] = 1'b0;
        req_a[r] = 4'($urandom);      // operands need not be held after accept
        req_b[r] = 4'($urandom);
        req_op[r] = 2'($urandom);
        #1;
        chk({tag, ".exec_quiet"}, {req_ready, rsp_valid}, 0);
        tick();
        for (int s = 0; s <= stall; s++) begin
            chk({tag, ".rsp_valid"}, rsp_valid, 32'(2'b01 << r));
            chk({tag, ".rsp_data"}, {rsp_err, rsp_cout, rsp_result}, exp);
            if (s == stall) rsp_ready[r] = 1'b1;
            else            rsp_ready[1-r] = poke;
            tick();
        end
        rsp_ready = 2'b00;
        chk({tag, ".rsp_drop"}, rsp_valid, 0);
    endtask

    // Protocol invariants every cycle out of reset
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("onehot_and_exclusive",
                {31'd0, (rsp_valid != 2'b00 && req_ready != 2'b00) ||
                        rsp_valid == 2'b11 || req_ready == 2'b11}, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        logic [3:0] ra, rb;
        logic [1:0] rop;
        int who;

        vt[0]  = '{0, 4'h7, 4'h9, 2'd0, 4'h0, 1'b1, 1'b0};
        vt[1]  = '{1, 4'h5, 4'h7, 2'd1, 4'hE, 1'b0, 1'b0};
        vt[2]  = '{0, 4'h8, 4'h2, 2'd2, 4'hE, 1'b0, 1'b0};
        vt[3]  = '{1, 4'h3, 4'h5, 2'd3, 4'h0, 1'b0, 1'b1};
        vt[4]  = '{0, 4'hF, 4'h1, 2'd0, 4'h0, 1'b1, 1'b0};
        vt[5]  = '{1, 4'h0, 4'h1, 2'd1, 4'hF, 1'b0, 1'b0};
        vt[6]  = '{0, 4'h7, 4'hB, 2'd2, 4'h0, 1'b0, 1'b0};
        vt[7]  = '{1, 4'hF, 4'h1, 2'd2, 4'hF, 1'b0, 1'b0};
        vt[8]  = '{0, 4'h3, 4'h4, 2'd0, 4'h7, 1'b0, 1'b0};
        vt[9]  = '{1, 4'h9, 4'h4, 2'd2, 4'h9, 1'b0, 1'b0};
        vt[10] = '{0, 4'h8, 4'h9, 2'd1, 4'hF, 1'b0, 1'b0};
        vt[11] = '{1, 4'hA, 4'h6, 2'd0, 4'h0, 1'b1, 1'b0};

        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0;
        #12;
        chk("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err}, 0);

        // Directed vectors
        for (int i = 0; i < 12; i++)
            do_op(vt[i].r, vt[i].a, vt[i].b, vt[i].op,
                  {vt[i].err, vt[i].cout, vt[i].res}, i % 3, 1'b1, $sformatf("vec%0d", i));

        // Stalled response with R0 pending a new request
        req_a[0] = 4'h2; req_b[0] = 4'h3; req_op[0] = 2'd0; req_valid[0] = 1'b1;
        #1; chk("stall.grant", req_ready, 2'b01);
        tick();
        req_a[0] = 4'h1; req_b[0] = 4'h1;
        #1; chk("stall.exec_ready", req_ready, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall.rsp_valid", rsp_valid, 2'b01);
            chk("stall.result", {rsp_err, rsp_cout, rsp_result}, 6'h05);
            chk("stall.req_ready", req_ready, 0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready = 2'b00;
        #1;
        chk("stall.released", rsp_valid, 0);
        chk("stall.pending_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        chk("stall.second_result", {rsp_valid, rsp_err, rsp_cout, rsp_result}, {2'b01, 6'h02});
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready = 2'b00;

        // Asynchronous reset during EXEC (R0 served last, R1 in flight)
        req_a[1] = 4'h3; req_b[1] = 4'h4; req_op[1] = 2'd0; req_valid[1] = 1'b1;
        #1; chk("rst.grant_r1", req_ready, 2'b10);
        tick();
        req_valid = 2'b11;
        req_a[0] = 4'h6; req_b[0] = 4'h1; req_op[0] = 2'd1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async_outputs", {req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err}, 0);
        tick(); tick();
        chk("rst.held_outputs", {req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst.first_grant_r0", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        chk("rst.rsp", {rsp_valid, rsp_err, rsp_cout, rsp_result}, {2'b01, 6'h05});
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready = 2'b00;

        // R1 withdraws before it can be granted while R0 is busy
        req_a[0] = 4'h1; req_b[0] = 4'h2; req_op[0] = 2'd0; req_valid[0] = 1'b1;
        #1; chk("withdraw.grant_r0", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        chk("withdraw.rsp", {rsp_valid, rsp_err, rsp_cout, rsp_result}, {2'b01, 6'h03});
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("withdraw.no_activity", {req_ready, rsp_valid}, 0);
            tick();
        end

        // Both valid from reset: strict alternation starting with R0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_a[0] = 4'h5; req_b[0] = 4'h7; req_op[0] = 2'd1;
        req_a[1] = 4'h8; req_b[1] = 4'h2; req_op[1] = 2'd2;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        who = 0;
        for (int i = 0; i < 6; i++) begin
            int w;
            #1;
            w = 0;
            while (req_ready == 2'b00 && w < 10) begin tick(); #1; w++; end
            chk("alt.grant", req_ready, 32'(2'b01 << who));
            tick();
            chk("alt.exec_quiet", rsp_valid, 0);
            tick();
            chk("alt.rsp", {rsp_valid, rsp_err, rsp_cout, rsp_result},
                {2'(2'b01 << who), 6'h0E});
            who ^= 1;
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();

        // Randomized single-requester traffic against the model
        for (int i = 0; i < 40; i++) begin
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rop = 2'($urandom);
            do_op(int'($urandom_range(0, 1)), ra, rb, rop, model(ra, rb, rop),
                  int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_au_arbiter
`default_nettype wire
